// File: rtl/mat_reg_file_pkg.sv
// Shared types for the matrix register file.
//   MatRegOp_t    : command opcodes on the cmd_op port
//   MatRegState_t : transpose sequencer state
//   diag_col      : column index of element i on wrapped diagonal d
package MatRegPkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_WR_ROW    = 4'd1,
    OP_WR_COL    = 4'd2,
    OP_WR_SCALAR = 4'd3,
    OP_WR_DIAG   = 4'd4,
    OP_RD_ROW    = 4'd5,
    OP_RD_COL    = 4'd6,
    OP_RD_SCALAR = 4'd7,
    OP_RD_DIAG   = 4'd8,
    OP_XPOSE     = 4'd9
  } MatRegOp_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_XPOSE = 1'b1
  } MatRegState_t;

  // (d - i) mod width, kept non-negative for any i.
  function automatic int unsigned diag_col(input int unsigned d,
                                           input int unsigned i,
                                           input int unsigned width);
    return (d + width - (i % width)) % width;
  endfunction

endpackage

// File: rtl/mat_reg_file_xpose_fsm.sv
// Sequencer for the in-place transpose.
//   clock_i, reset_ni : clock, asynchronous active-low reset
//   start_i           : transpose command accepted this cycle
//   busy_o            : transpose in progress
//   swap_en_o         : swap row/column swap_k_o on this edge
//   swap_k_o          : current pivot index k
module mat_reg_xpose_fsm
  import MatRegPkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             swap_en_o,
  output logic [IDX_W-1:0] swap_k_o
);

  MatRegState_t     state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_XPOSE;
          k_d     = '0;
        end
      end
      ST_XPOSE: begin
        // Pivot WIDTH-1 has no elements above it, so the sweep stops at WIDTH-2.
        if (k_q == IDX_W'(WIDTH - 2)) begin
          state_d = ST_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  assign busy_o    = (state_q == ST_XPOSE);
  assign swap_en_o = (state_q == ST_XPOSE);
  assign swap_k_o  = k_q;

endmodule

// File: rtl/mat_reg_file.sv
// Multi-bank matrix register file: NUM_REGS matrices of WIDTH x WIDTH
// elements, DATA_WIDTH bits each. Row/column/scalar/diagonal access over a
// valid/ready command port, registered read response with backpressure,
// and a multi-cycle in-place transpose.
//   clock, reset_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op, cmd_reg       : operation and target matrix
//   cmd_param1/cmd_param2 : row/column/diagonal index, scalar column
//   cmd_data              : write vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : read vector, same packing as cmd_data
//   busy                  : transpose in progress
module mat_reg_file
  import MatRegPkg::*;
#(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_REGS   = 4,
  localparam int unsigned IDX_W      = $clog2(WIDTH),
  localparam int unsigned REG_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  MatRegOp_t                   cmd_op,
  input  logic [REG_W-1:0]            cmd_reg,
  input  logic [IDX_W-1:0]            cmd_param1,
  input  logic [IDX_W-1:0]            cmd_param2,
  input  logic [WIDTH*DATA_WIDTH-1:0] cmd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH*DATA_WIDTH-1:0] rsp_data,
  output logic                        busy
);

  localparam int unsigned VEC_W = WIDTH * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS][WIDTH][WIDTH];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS][WIDTH][WIDTH];

  logic             rsp_valid_q, rsp_valid_d;
  logic [VEC_W-1:0] rsp_data_q, rsp_data_d;
  logic [REG_W-1:0] xpose_reg_q, xpose_reg_d;
  logic             xpose_ok_q, xpose_ok_d;

  logic             cmd_fire;
  logic             reg_ok;
  logic             xp_busy;
  logic             swap_en;
  logic [IDX_W-1:0] swap_k;
  logic [IDX_W-1:0] dc;

  if ((1 << REG_W) == NUM_REGS) begin : g_reg_pow2
    assign reg_ok = 1'b1;
  end else begin : g_reg_range
    assign reg_ok = (32'(cmd_reg) < NUM_REGS);
  end

  assign cmd_ready = !xp_busy && (!rsp_valid_q || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;

  mat_reg_xpose_fsm #(
    .WIDTH(WIDTH)
  ) u_xpose_fsm (
    .clock_i   (clock),
    .reset_ni  (reset_n),
    .start_i   (cmd_fire && (cmd_op == OP_XPOSE)),
    .busy_o    (xp_busy),
    .swap_en_o (swap_en),
    .swap_k_o  (swap_k)
  );

  always_comb begin
    mem_d       = mem_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    xpose_reg_d = xpose_reg_q;
    xpose_ok_d  = xpose_ok_q;
    dc          = '0;

    // Transpose step: exchange the part of row k right of the diagonal with
    // the part of column k below it. Commands are blocked while this runs.
    if (swap_en && xpose_ok_q) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (j > 32'(swap_k)) begin
          mem_d[xpose_reg_q][swap_k][j] = mem_q[xpose_reg_q][j][swap_k];
          mem_d[xpose_reg_q][j][swap_k] = mem_q[xpose_reg_q][swap_k][j];
        end
      end
    end

    if (cmd_fire) begin
      unique case (cmd_op)
        OP_WR_ROW: begin
          if (reg_ok) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
              mem_d[cmd_reg][cmd_param1][j] = cmd_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        OP_WR_COL: begin
          if (reg_ok) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              mem_d[cmd_reg][i][cmd_param1] = cmd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        OP_WR_SCALAR: begin
          if (reg_ok) begin
            mem_d[cmd_reg][cmd_param1][cmd_param2] = cmd_data[DATA_WIDTH-1:0];
          end
        end
        OP_WR_DIAG: begin
          if (reg_ok) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              dc = IDX_W'(diag_col(32'(cmd_param1), i, WIDTH));
              mem_d[cmd_reg][i][dc] = cmd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        OP_RD_ROW: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          if (reg_ok) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
              rsp_data_d[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[cmd_reg][cmd_param1][j];
            end
          end
        end
        OP_RD_COL: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          if (reg_ok) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[cmd_reg][i][cmd_param1];
            end
          end
        end
        OP_RD_SCALAR: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          if (reg_ok) begin
            rsp_data_d[DATA_WIDTH-1:0] = mem_q[cmd_reg][cmd_param1][cmd_param2];
          end
        end
        OP_RD_DIAG: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          if (reg_ok) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              dc = IDX_W'(diag_col(32'(cmd_param1), i, WIDTH));
              rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[cmd_reg][i][dc];
            end
          end
        end
        OP_XPOSE: begin
          // Target is latched so the sweep is independent of later cmd_reg values.
          xpose_reg_d = cmd_reg;
          xpose_ok_d  = reg_ok;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          for (int unsigned j = 0; j < WIDTH; j++) begin
            mem_q[r][i][j] <= '0;
          end
        end
      end
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      xpose_reg_q <= '0;
      xpose_ok_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      xpose_reg_q <= xpose_reg_d;
      xpose_ok_q  <= xpose_ok_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = xp_busy;

endmodule
